// File: rtl/mdu_hilo_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and counter width.
package mdu_hilo_pkg;

  localparam int unsigned OpW  = 3;
  localparam int unsigned CntW = 4;

  typedef enum logic [OpW-1:0] {
    MduMult  = 3'd0,
    MduMultu = 3'd1,
    MduDiv   = 3'd2,
    MduDivu  = 3'd3,
    MduMthi  = 3'd4,
    MduMtlo  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// IDLE/RUN sequencer for the MDU: loads a cycle count on start, holds busy, pulses done.
module mdu_seq
  import mdu_hilo_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_md_i,
  input  logic [CntW-1:0] n_i,
  output logic            busy_o,
  output logic            done_o
);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_md_i) begin
          cnt_d   = n_i;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == CntW'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only, so busy has no path from start.
  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StRun) && (cnt_q == CntW'(1));
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [OpW-1:0] op,
  input  logic [31:0]    A,
  input  logic [31:0]    B,
  output logic           busy,
  output logic [31:0]    HI,
  output logic [31:0]    LO
);

  localparam logic [CntW-1:0] MultN = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivN  = CntW'(DIV_CYCLES);

  logic            accept, start_md, is_div, is_signed, done;
  logic [CntW-1:0] n_cycles;

  assign accept    = start && !busy;
  assign start_md  = accept && !op[2];
  assign is_div    = op[1];
  assign is_signed = !op[0];
  assign n_cycles  = is_div ? DivN : MultN;

  mdu_seq u_seq (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_md_i (start_md),
    .n_i        (n_cycles),
    .busy_o     (busy),
    .done_o     (done)
  );

  // Arithmetic
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, divisor, uq, ur, quo, rem;
  logic [63:0] result;

  always_comb begin
    mul_a    = {{32{A[31] & is_signed}}, A};
    mul_b    = {{32{B[31] & is_signed}}, B};
    prod     = mul_a * mul_b;
    // Divide on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
    a_neg    = is_signed & A[31];
    b_neg    = is_signed & B[31];
    a_mag    = a_neg ? (32'd0 - A) : A;
    b_mag    = b_neg ? (32'd0 - B) : B;
    div_zero = (B == 32'd0);
    divisor  = div_zero ? 32'd1 : b_mag;
    uq       = a_mag / divisor;
    ur       = a_mag % divisor;
    quo      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem      = a_neg ? (32'd0 - ur) : ur;
    result   = is_div ? {rem, quo} : prod;
  end

  // Pending result and HI/LO
  logic [31:0] phi_q, phi_d, plo_q, plo_d, hi_q, hi_d, lo_q, lo_d;
  logic        skip_q, skip_d;

  always_comb begin
    phi_d  = phi_q;
    plo_d  = plo_q;
    skip_d = skip_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start_md) begin
      phi_d  = result[63:32];
      plo_d  = result[31:0];
      skip_d = is_div && div_zero;
    end
    if (done) begin
      if (!skip_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (accept && (op == MduMthi)) begin
      hi_d = A;
    end else if (accept && (op == MduMtlo)) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phi_q  <= '0;
      plo_q  <= '0;
      skip_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      skip_q <= skip_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: mult/div results, busy length, dz, overlap and async reset.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  int ignored_starts = 0;
  int n;

  always #5 clk = ~clk;

  mdu_hilo #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  // Hazard-protocol monitor: a start while busy must never reach the unit.
  always @(posedge clk) begin
    if (!reset && start && busy) begin
      ignored_starts++;
      $display("note: start presented while busy at %0t", $time);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents the request for one rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd7;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd7;
    a     = '0;
    b     = '0;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    check("mult_busy_len", n, 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    check("multu_busy_len", n, 5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    check("div_busy_len", n, 10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    issue(3'd4, 32'h0000_1234, 32'h0);
    check("mthi_pre_hi", hi, 32'h0000_1234);
    issue(3'd5, 32'h0000_5678, 32'h0);
    check("mtlo_pre_lo", lo, 32'h0000_5678);
    issue(3'd3, 32'h0000_0063, 32'h0);
    check("dz_busy_start", 32'(busy), 32'h1);
    wait_idle(n);
    check("dz_busy_len", n, 10);
    check("dz_hi", hi, 32'h0000_1234);
    check("dz_lo", lo, 32'h0000_5678);

    // Overlap: requests during busy are dropped.
    issue(3'd1, 32'h3, 32'h4);
    check("ovl_busy", 32'(busy), 32'h1);
    @(negedge clk);
    issue(3'd1, 32'd100, 32'd100);
    issue(3'd5, 32'h0000_AAAA, 32'h0);
    wait_idle(n);
    check("ovl_remaining", n, 2);
    check("ovl_hi", hi, 32'h0);
    check("ovl_lo", lo, 32'h0000_000C);
    check("ovl_ignored", ignored_starts, 2);

    // Start in the first idle cycle after busy falls.
    issue(3'd0, 32'hFFFF_FFFE, 32'h3);
    check("b2b_busy", 32'(busy), 32'h1);
    wait_idle(n);
    check("b2b_busy_len", n, 5);
    check("b2b_hi", hi, 32'hFFFF_FFFF);
    check("b2b_lo", lo, 32'hFFFF_FFFA);

    issue(3'd6, 32'h5, 32'h5);
    check("rsvd_busy", 32'(busy), 32'h0);
    check("rsvd_hi", hi, 32'hFFFF_FFFF);
    check("rsvd_lo", lo, 32'hFFFF_FFFA);

    issue(3'd4, 32'hDEAD_BEEF, 32'h0);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_busy", 32'(busy), 32'h0);
    check("mthi_lo", lo, 32'hFFFF_FFFA);

    // Asynchronous reset mid-divide.
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_hi", hi, 32'h0);
    check("rst_async_lo", lo, 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_later_hi", hi, 32'h0);
    check("rst_later_lo", lo, 32'h0);
    check("rst_later_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
